// File: rtl/btn_event.sv
`default_nettype none
// ============================================================================
// Module   : btn_event
// Brief    : Debounced button level -> press/release/long-press/repeat pulses
// Revision : 1.0
// ============================================================================
module btn_event #(
  parameter int HOLD_TICKS   = 500,
  parameter int REPEAT_TICKS = 100,
  parameter int CNT_W        = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_in,
  input  logic i_tick,
  output logic o_press,
  output logic o_release,
  output logic o_long_press,
  output logic o_rpt,
  output logic o_held
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(HOLD_TICKS - 1);
  // Clamped so a disabled repeat still yields a well-formed constant
  localparam logic [CNT_W-1:0] c_rpt_last  = CNT_W'((REPEAT_TICKS == 0) ? 0 : REPEAT_TICKS - 1);
  localparam bit               c_rpt_en    = (REPEAT_TICKS != 0);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      o_press      <= 1'b0;
      o_release    <= 1'b0;
      o_long_press <= 1'b0;
      o_rpt        <= 1'b0;
      o_held       <= 1'b0;
    end else begin
      o_press      <= 1'b0;
      o_release    <= 1'b0;
      o_long_press <= 1'b0;
      o_rpt        <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_in) begin
            r_state <= S_HOLD;
            r_cnt   <= '0;
            o_press <= 1'b1;
            o_held  <= 1'b1;
          end else begin
            o_held  <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!i_in) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            o_release <= 1'b1;
            o_held    <= 1'b0;
          end else begin
            o_held <= 1'b1;
            if (i_tick) begin
              if (r_cnt == c_hold_last) begin
                r_state      <= S_REPEAT;
                r_cnt        <= '0;
                o_long_press <= 1'b1;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end
        end
        S_REPEAT: begin
          if (!i_in) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            o_release <= 1'b1;
            o_held    <= 1'b0;
          end else begin
            o_held <= 1'b1;
            if (i_tick && c_rpt_en) begin
              if (r_cnt == c_rpt_last) begin
                r_cnt <= '0;
                o_rpt <= 1'b1;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          o_held  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_btn_event.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_event
// Brief    : Randomized bench for btn_event against a tick-count event model
// Revision : 1.0
// ============================================================================
module tb_btn_event;

  localparam int HT  = 4;
  localparam int RTA = 3;
  localparam int RTB = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic r_in  = 1'b0;
  logic r_tick = 1'b0;

  logic w_press_a, w_release_a, w_long_a, w_rpt_a, w_held_a;
  logic w_press_b, w_release_b, w_long_b, w_rpt_b, w_held_b;

  int n_cmp = 0;
  int n_err = 0;

  // Model: per instance, whether pressed and ticks counted since the press edge
  bit         m_pr[2];
  int         m_k[2];
  logic [4:0] m_exp[2];

  always #5 clk = ~clk;

  btn_event #(.HOLD_TICKS(HT), .REPEAT_TICKS(RTA), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_in(r_in), .i_tick(r_tick),
    .o_press(w_press_a), .o_release(w_release_a), .o_long_press(w_long_a),
    .o_rpt(w_rpt_a), .o_held(w_held_a)
  );

  btn_event #(.HOLD_TICKS(HT), .REPEAT_TICKS(RTB), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_in(r_in), .i_tick(r_tick),
    .o_press(w_press_b), .o_release(w_release_b), .o_long_press(w_long_b),
    .o_rpt(w_rpt_b), .o_held(w_held_b)
  );

  task automatic chk_eq(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got {prs,rel,lng,rpt,hld}=%b want %b", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pr[i]  = 1'b0;
      m_k[i]   = 0;
      m_exp[i] = 5'b0;
    end
  endtask

  task automatic model_step(input logic vin, input logic vt);
    for (int i = 0; i < 2; i++) begin
      int   rt;
      logic p, r, l, q;
      rt = (i == 0) ? RTA : RTB;
      {p, r, l, q} = 4'b0;
      if (!m_pr[i]) begin
        if (vin) begin
          m_pr[i] = 1'b1;
          m_k[i]  = 0;
          p = 1'b1;
        end
      end else if (!vin) begin
        m_pr[i] = 1'b0;
        r = 1'b1;
      end else if (vt) begin
        m_k[i]++;
        if (m_k[i] == HT) l = 1'b1;
        else if (m_k[i] > HT && rt != 0 && ((m_k[i] - HT) % rt) == 0) q = 1'b1;
      end
      m_exp[i] = {p, r, l, q, m_pr[i]};
    end
  endtask

  task automatic check_both(input string tag);
    chk_eq({tag, "_a"}, {w_press_a, w_release_a, w_long_a, w_rpt_a, w_held_a}, m_exp[0]);
    chk_eq({tag, "_b"}, {w_press_b, w_release_b, w_long_b, w_rpt_b, w_held_b}, m_exp[1]);
  endtask

  // Called at a negedge: drive, clock once, update model, check on next negedge
  task automatic cyc(input string tag, input logic vin, input logic vt);
    r_in   = vin;
    r_tick = vt;
    @(posedge clk);
    model_step(vin, vt);
    @(negedge clk);
    check_both(tag);
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      r_in   = 1'b1;
      r_tick = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      check_both("in_reset");
    end
  endtask

  task automatic run_random(input int n);
    logic lvl;
    int   left;
    bit   dense;
    lvl  = 1'b0;
    left = 0;
    dense = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (left == 0) begin
        lvl   = ~lvl;
        left  = lvl ? int'($urandom_range(1, 24)) : int'($urandom_range(1, 4));
        dense = ($urandom_range(0, 1) == 1);
      end
      left--;
      cyc("rand", lvl, dense ? 1'b1 : 1'($urandom_range(0, 2) == 0));
    end
  endtask

  initial begin
    model_reset();
    r_in  = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    reset_cycles(3);
    rst_n = 1'b1;
    cyc("rst_press", 1'b1, 1'b1);
    cyc("rst_held", 1'b1, 1'b0);
    cyc("rst_rel", 1'b0, 1'b0);
    cyc("idle", 1'b0, 1'b1);

    // Continuous ticks, 12 cycles high then low
    for (int i = 0; i < 12; i++) cyc("dense", 1'b1, 1'b1);
    cyc("dense_rel", 1'b0, 1'b1);
    cyc("dense_idle", 1'b0, 1'b1);

    // Short hold: release before hold time
    cyc("short", 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc("short", 1'b1, 1'b1);
    cyc("short_rel", 1'b0, 1'b0);

    // Release coincides with the tick that would fire long_press
    cyc("race", 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc("race", 1'b1, 1'b1);
    cyc("race_rel", 1'b0, 1'b1);
    cyc("race_idle", 1'b0, 1'b0);

    // Press-release-press on consecutive cycles
    cyc("prp", 1'b1, 1'b0);
    cyc("prp", 1'b0, 1'b0);
    cyc("prp", 1'b1, 1'b0);
    cyc("prp", 1'b0, 1'b0);

    // Long hold well past long_press, then reset in REPEAT
    for (int i = 0; i < 28; i++) cyc("long", 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_both("async_rst");
    @(negedge clk);
    reset_cycles(2);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) cyc("post_rst", 1'b1, 1'b1);
    cyc("post_rst_rel", 1'b0, 1'b0);

    run_random(3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
